// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential fetch, credit-limited requests, in-order response queue.
module fetch_unit #(
  parameter int unsigned   WIDTH    = 32,
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [AW-1:0]    mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [AW-1:0]    inst_pc,
  input  logic             redirect,
  input  logic [AW-1:0]    redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  logic [AW-1:0]    fetch_pc;
  logic [AW-1:0]    resp_pc;
  logic [WIDTH-1:0] q_inst [DEPTH];
  logic [AW-1:0]    q_pc   [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    live;
  logic [CW-1:0]    drop;

  logic [SW-1:0]    credit_sum_c;
  logic             req_fire_c;
  logic             resp_keep_c;
  logic             resp_drop_c;
  logic             resp_seen_c;
  logic             pop_c;
  logic [AW-1:0]    target_pc_c;
  logic             unused_redirect_lsbs;

  // Low address bits of a redirect target are ignored.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc_c          = {redirect_pc[AW-1:2], 2'b00};

  // Credit check: queued + in-flight (kept or discarded) never exceeds the queue size.
  always_comb begin
    credit_sum_c  = SW'(occ) + SW'(live) + SW'(drop);
    mem_req_valid = !rst && !redirect && (credit_sum_c < SW'(DEPTH));
    mem_req_addr  = fetch_pc;
    req_fire_c    = mem_req_valid && mem_req_ready;
    resp_drop_c   = mem_resp_valid && (drop != '0);
    resp_keep_c   = mem_resp_valid && (drop == '0) && (live != '0);
    resp_seen_c   = mem_resp_valid && ((drop != '0) || (live != '0));
    inst_valid    = (occ != '0);
    inst          = q_inst[rd_ptr];
    inst_pc       = q_pc[rd_ptr];
    pop_c         = inst_valid && inst_ready;
  end

  // Fetch PC, queue storage and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      live     <= '0;
      drop     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Everything in flight becomes garbage; a response arriving now is the first of it.
      fetch_pc <= target_pc_c;
      resp_pc  <= target_pc_c;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      live     <= '0;
      drop     <= drop + live - CW'(resp_seen_c);
    end else begin
      if (req_fire_c) begin
        fetch_pc <= fetch_pc + AW'(4);
      end
      if (resp_keep_c) begin
        q_inst[wr_ptr] <= mem_resp_data;
        q_pc[wr_ptr]   <= resp_pc;
        wr_ptr         <= wr_ptr + PW'(1);
        resp_pc        <= resp_pc + AW'(4);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (resp_drop_c) begin
        drop <= drop - CW'(1);
      end
      occ  <= occ + CW'(resp_keep_c) - CW'(pop_c);
      live <= live + CW'(req_fire_c) - CW'(resp_keep_c);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory and a PC scoreboard.
module tb_fetch_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [AW-1:0]    mem_req_addr;
  logic             mem_resp_valid = 1'b0;
  logic [WIDTH-1:0] mem_resp_data = '0;
  logic             inst_valid;
  logic             inst_ready = 1'b0;
  logic [WIDTH-1:0] inst;
  logic [AW-1:0]    inst_pc;
  logic             redirect = 1'b0;
  logic [AW-1:0]    redirect_pc = '0;

  fetch_unit #(
    .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mem_word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  // In-order memory: each accepted request returns after lat cycles (>= 1).
  int unsigned   cyc = 0;
  int unsigned   lat = 1;
  int            acc_count = 0;
  logic [AW-1:0] mq_addr [$];
  int unsigned   mq_due  [$];

  always @(posedge clk) begin
    logic [AW-1:0] a;
    cyc++;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (mem_req_valid && mem_req_ready) begin
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(cyc + lat - 1);
      acc_count++;
    end
    #1;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      a = mq_addr.pop_front();
      void'(mq_due.pop_front());
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(a);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  end

  // Scoreboard: consumed PCs run sequentially from reset or the last redirect target.
  logic [AW-1:0] exp_pc = '0;
  int            hs_count = 0;
  bit            rec = 1'b0;
  logic [AW-1:0] seen [$];

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 16'h0000;
    end else begin
      if (inst_valid && inst_ready) begin
        check("sb_inst_pc", 64'(inst_pc), 64'(exp_pc));
        check("sb_inst", 64'(inst), 64'(mem_word(exp_pc)));
        if (rec) seen.push_back(inst_pc);
        exp_pc   = exp_pc + 16'd4;
        hs_count++;
      end
      if (redirect) exp_pc = {redirect_pc[AW-1:2], 2'b00};
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    step(2);
    @(negedge clk);
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_req_addr", 64'(mem_req_addr), 64'(16'h0000));
    check("rst_inst_valid", 64'(inst_valid), 64'(0));
    check("rst_inst", 64'(inst), 64'(0));
    check("rst_inst_pc", 64'(inst_pc), 64'(0));
    step();
    rst = 1'b0;
  endtask

  int h0;
  int a0;

  initial begin
    // 1: streaming at one instruction per cycle
    lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    step(5);
    h0 = hs_count;
    step(20);
    check("t1_throughput", 64'(hs_count - h0), 64'(20));

    // 2: consumer stalled -> exactly DEPTH requests, then drain in order
    inst_ready = 1'b0;
    do_reset();
    a0 = acc_count;
    step(10);
    @(negedge clk);
    check("t2_accepted", 64'(acc_count - a0), 64'(4));
    check("t2_req_valid", 64'(mem_req_valid), 64'(0));
    check("t2_req_addr", 64'(mem_req_addr), 64'(16'h0010));
    check("t2_head_valid", 64'(inst_valid), 64'(1));
    check("t2_head_pc", 64'(inst_pc), 64'(16'h0000));
    check("t2_head_inst", 64'(inst), 64'(mem_word(16'h0000)));
    step();
    inst_ready = 1'b1;
    h0 = hs_count;
    step(12);
    check("t2_drain", 64'((hs_count - h0) >= 8), 64'(1));

    // 3: redirect with two requests in flight at latency 3
    lat = 3; mem_req_ready = 1'b0; inst_ready = 1'b1;
    do_reset();
    mem_req_ready = 1'b1;
    step(2);
    mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0102;
    @(negedge clk);
    check("t3_no_req_in_redirect", 64'(mem_req_valid), 64'(0));
    step();
    redirect = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check("t3_req_valid", 64'(mem_req_valid), 64'(1));
    check("t3_req_addr", 64'(mem_req_addr), 64'(16'h0100));
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      check("t3_queue_empty", 64'(inst_valid), 64'(0));
      step();
    end
    h0 = hs_count;
    step(10);
    check("t3_progress", 64'(hs_count > h0), 64'(1));

    // 4: redirect coinciding with a response and a consume handshake
    lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    step(8);
    redirect = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    check("t4_hs_in_redirect", 64'(inst_valid), 64'(1));
    check("t4_resp_in_redirect", 64'(mem_resp_valid), 64'(1));
    check("t4_no_req", 64'(mem_req_valid), 64'(0));
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("t4_flushed", 64'(inst_valid), 64'(0));
    check("t4_req_addr", 64'(mem_req_addr), 64'(16'h0200));
    step();
    @(negedge clk);
    check("t4_no_stale", 64'(inst_valid), 64'(0));
    step(6);

    // 5: address wrap at the top of the space
    redirect = 1'b1; redirect_pc = 16'hFFFA;
    step();
    redirect = 1'b0;
    seen.delete();
    rec = 1'b1;
    step(12);
    rec = 1'b0;
    check("t5_count", 64'(seen.size() >= 4), 64'(1));
    if (seen.size() >= 4) begin
      check("t5_pc0", 64'(seen[0]), 64'(16'hFFF8));
      check("t5_pc1", 64'(seen[1]), 64'(16'hFFFC));
      check("t5_pc2", 64'(seen[2]), 64'(16'h0000));
      check("t5_pc3", 64'(seen[3]), 64'(16'h0004));
    end

    // 6: random ready/latency/redirects with a reset mid-run
    h0 = hs_count;
    for (int c = 0; c < 6000; c++) begin
      if (c == 3000) begin
        redirect = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("t6_rst_req_valid", 64'(mem_req_valid), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_inst_valid", 64'(inst_valid), 64'(0));
        check("t6_rst_req_addr", 64'(mem_req_addr), 64'(16'h0000));
        step();
      end else begin
        mem_req_ready = ($urandom_range(0, 3) != 0);
        inst_ready    = ($urandom_range(0, 3) != 0);
        lat           = $urandom_range(1, 4);
        redirect      = ($urandom_range(0, 63) == 0);
        redirect_pc   = AW'($urandom);
        step();
      end
    end
    redirect = 1'b0;
    step(20);
    check("t6_progress", 64'((hs_count - h0) > 1000), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
